tanh_seq_ctrl: RTL and testbench

Streaming front-end sequencer for the tanh CORDIC core (`myCordic`). It accepts input angles over a valid/ready handshake and bypasses the core for out-of-range arguments by emitting ±1 directly. For in-range arguments it issues a one-cycle `Start`, waits for `Done` under a watchdog, clamps the returned result to [-1, +1], and presents it on a valid/ready output stream. It sits between the sample source and `myCordic`, and owns all flow control around the core.

---
 rtl/tanh_pkg.sv | 17 +
 rtl/tanh_wdog.sv | 23 ++
 rtl/tanh_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_tanh_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tanh_pkg.sv
// Shared types and constants for the tanh CORDIC front-end sequencer.
package tanh_pkg;
    localparam int WI  = 4;
    localparam int WF  = 16;
    localparam int WIO = 8;
    localparam int WFO = 16;
    localparam int WX  = WI + WF;
    localparam int WO  = WIO + WFO;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

    localparam logic signed [WO-1:0] ONE_O       = {{(WIO-1){1'b0}}, 1'b1, {WFO{1'b0}}};
    localparam logic signed [WO-1:0] MINUS_ONE_O = -ONE_O;

    localparam logic signed [WX-1:0] SAT_TH_DFLT  = 20'sh64000;
    localparam int                   TMO_CYC_DFLT = 64;
endpackage

// File: rtl/tanh_wdog.sv
// Watchdog for the WAIT state: clearable, enabled up-counter with terminal-count flag.
module tanh_wdog #(
    parameter int TMO_CYC = 64
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge Clk) begin
        if (Rst || clr)
            count <= '0;
        else if (en)
            count <= count + CW'(1);
    end

    assign tc = (count == CW'(TMO_CYC - 1));
endmodule

// File: rtl/tanh_seq_ctrl.sv
// Sequencer around myCordic: input handshake, bypass for large |X|, core launch
// with watchdog, result clamp to [-1, +1], and a held valid/ready output.
module tanh_seq_ctrl
    import tanh_pkg::*;
#(
    parameter int                          WI      = tanh_pkg::WI,
    parameter int                          WF      = tanh_pkg::WF,
    parameter int                          WIO     = tanh_pkg::WIO,
    parameter int                          WFO     = tanh_pkg::WFO,
    parameter logic signed [WI+WF-1:0]     SAT_TH  = SAT_TH_DFLT,
    parameter int                          TMO_CYC = TMO_CYC_DFLT
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [WI+WF-1:0]     InX,
    output logic                 CStart,
    output logic [WI+WF-1:0]     CX,
    input  logic                 CDone,
    input  logic [WIO+WFO-1:0]   CTanh,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [WIO+WFO-1:0]   OutY,
    output logic                 OutSat,
    output logic                 OutErr
);
    localparam int NX = WI + WF;
    localparam int NO = WIO + WFO;

    localparam logic signed [NX-1:0] NEG_TH = -SAT_TH;
    localparam logic signed [NX-1:0] MIN_X  = {1'b1, {(NX-1){1'b0}}};
    localparam logic signed [NO-1:0] ONE    = {{(WIO-1){1'b0}}, 1'b1, {WFO{1'b0}}};
    localparam logic signed [NO-1:0] M_ONE  = -ONE;

    state_t state, state_nxt;

    logic                 tc;
    logic                 bypass;
    logic                 clamped;
    logic signed [NX-1:0] x_s;
    logic signed [NO-1:0] t_s;
    logic signed [NO-1:0] clamp_y;

    logic [NX-1:0] arg;
    logic [NO-1:0] result;
    logic          sat_flag;
    logic          err_flag;

    // The most-negative code has no positive counterpart, so it saturates too.
    assign x_s    = InX;
    assign bypass = (x_s >= SAT_TH) || (x_s <= NEG_TH) || (x_s == MIN_X);

    assign t_s = CTanh;
    always_comb begin
        clamp_y = t_s;
        clamped = 1'b0;
        if (t_s > ONE) begin
            clamp_y = ONE;
            clamped = 1'b1;
        end else if (t_s < M_ONE) begin
            clamp_y = M_ONE;
            clamped = 1'b1;
        end
    end

    tanh_wdog #(.TMO_CYC(TMO_CYC)) u_wdog (
        .Clk (Clk),
        .Rst (Rst),
        .clr (state == LAUNCH),
        .en  (state == WAIT),
        .tc  (tc)
    );

    always_ff @(posedge Clk) begin
        if (Rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (InValid) state_nxt = bypass ? HOLD : LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (CDone || tc) state_nxt = HOLD;
            HOLD:    if (OutReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        InReady  = 1'b0;
        CStart   = 1'b0;
        OutValid = 1'b0;
        case (state)
            IDLE:    InReady  = 1'b1;
            LAUNCH:  CStart   = 1'b1;
            HOLD:    OutValid = 1'b1;
            default: ;
        endcase
    end

    // Result registers only change on acceptance or WAIT exit, so HOLD keeps them stable.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            arg      <= '0;
            result   <= '0;
            sat_flag <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (InValid) begin
                    arg <= InX;
                    if (bypass) begin
                        result   <= InX[NX-1] ? M_ONE : ONE;
                        sat_flag <= 1'b1;
                        err_flag <= 1'b0;
                    end
                end
                WAIT: if (CDone) begin
                    result   <= clamp_y;
                    sat_flag <= clamped;
                    err_flag <= 1'b0;
                end else if (tc) begin
                    result   <= '0;
                    sat_flag <= 1'b0;
                    err_flag <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign CX     = arg;
    assign OutY   = result;
    assign OutSat = sat_flag;
    assign OutErr = err_flag;
endmodule

// File: tb/tb_tanh_seq_ctrl.sv
// Bench for tanh_seq_ctrl: directed vector table, hand-written corner sequences,
// and randomized transactions checked against an integer reference model.
module tb_tanh_seq_ctrl;
    import tanh_pkg::*;

    localparam int TMO = 64;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        InValid;
    logic        InReady;
    logic [19:0] InX;
    logic        CStart;
    logic [19:0] CX;
    logic        CDone;
    logic [23:0] CTanh;
    logic        OutValid;
    logic        OutReady;
    logic [23:0] OutY;
    logic        OutSat;
    logic        OutErr;

    int n_cmp = 0;
    int n_bad = 0;

    tanh_seq_ctrl dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .InValid  (InValid),
        .InReady  (InReady),
        .InX      (InX),
        .CStart   (CStart),
        .CX       (CX),
        .CDone    (CDone),
        .CTanh    (CTanh),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutY     (OutY),
        .OutSat   (OutSat),
        .OutErr   (OutErr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [19:0] x;
        int          lat;
        logic [23:0] tanh;
        logic [23:0] ey;
        logic        es;
        logic        ee;
        int          ecyc;
        int          estarts;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // Reference: tanh with bypass/clamp/timeout rules in plain integer arithmetic.
    task automatic model(input logic [19:0] x, input int lat, input logic [23:0] tanh,
                         output logic [23:0] y, output logic s, output logic e,
                         output int cyc, output int starts);
        int sx, th, t, r;
        sx = int'($signed(x));
        th = 25 * 65536 / 4;
        s = 1'b0;
        e = 1'b0;
        if (sx >= th || sx <= -th || sx == -(1 << 19)) begin
            r = (sx < 0) ? -65536 : 65536;
            s = 1'b1;
            cyc = 1;
            starts = 0;
        end else if (lat >= 1 && lat <= TMO) begin
            t = int'($signed(tanh));
            r = t;
            if (t > 65536) begin r = 65536; s = 1'b1; end
            if (t < -65536) begin r = -65536; s = 1'b1; end
            cyc = 2 + lat;
            starts = 1;
        end else begin
            r = 0;
            e = 1'b1;
            cyc = 2 + TMO;
            starts = 1;
        end
        y = r[23:0];
    endtask

    // One transaction from acceptance (cycle 0) through the output handshake.
    task automatic run_txn(input logic [19:0] x, input int lat, input logic [23:0] tanh,
                           input int hold, input logic nxt_valid,
                           input logic [23:0] ey, input logic es, input logic ee,
                           input int ecyc, input int estarts);
        int cyc, starts, scyc;
        bit seen;
        logic [23:0] yh;
        logic sh, eh;
        starts = 0;
        scyc = 0;
        seen = 0;
        InX = x;
        InValid = 1'b1;
        chk("in_ready_idle", {31'd0, InReady}, 32'd1);
        tick();
        InValid = 1'b0;
        chk("cx_copy", {12'd0, CX}, {12'd0, x});
        cyc = 1;
        while (!seen && cyc < 200) begin
            if (CStart) begin starts++; scyc = cyc; end
            if (OutValid) begin
                seen = 1;
                CDone = 1'b0;
                chk("valid_cycle", cyc, ecyc);
                chk("out_y", {8'd0, OutY}, {8'd0, ey});
                chk("out_sat", {31'd0, OutSat}, {31'd0, es});
                chk("out_err", {31'd0, OutErr}, {31'd0, ee});
                chk("start_count", starts, estarts);
                if (estarts == 1) chk("start_cycle", scyc, 1);
                yh = OutY; sh = OutSat; eh = OutErr;
                for (int h = 0; h < hold; h++) begin
                    OutReady = 1'b0;
                    InValid = nxt_valid;
                    InX = 20'h90000;
                    tick();
                    chk("hold_valid", {31'd0, OutValid}, 32'd1);
                    chk("hold_y", {8'd0, OutY}, {8'd0, yh});
                    chk("hold_flags", {30'd0, OutSat, OutErr}, {30'd0, sh, eh});
                    chk("hold_in_ready", {31'd0, InReady}, 32'd0);
                    chk("hold_no_start", {31'd0, CStart}, 32'd0);
                end
                OutReady = 1'b1;
                tick();
                OutReady = 1'b0;
                chk("valid_drop", {31'd0, OutValid}, 32'd0);
            end else begin
                CDone = (lat > 0 && cyc == 1 + lat);
                CTanh = tanh;
                tick();
                cyc++;
            end
        end
        CDone = 1'b0;
        if (!seen) chk("output_never_valid", 0, 1);
    endtask

    initial begin
        logic [19:0] rx;
        logic [23:0] rt, my;
        logic ms, me;
        int rl, mc, mst;

        Rst = 1'b1; InValid = 1'b0; InX = '0; CDone = 1'b0; CTanh = '0; OutReady = 1'b0;
        tick(); tick();
        Rst = 1'b0;
        chk("rst_in_ready", {31'd0, InReady}, 32'd1);
        chk("rst_out", {8'd0, OutY}, 32'd0);
        chk("rst_flags", {28'd0, CStart, OutValid, OutSat, OutErr}, 32'd0);
        chk("rst_cx", {12'd0, CX}, 32'd0);

        vecs[0]  = '{20'h08000, 20, 24'h00764D, 24'h00764D, 1'b0, 1'b0, 22, 1};
        vecs[1]  = '{20'h70000, 0,  24'h000000, 24'h010000, 1'b1, 1'b0, 1,  0};
        vecs[2]  = '{20'h90000, 0,  24'h000000, 24'hFF0000, 1'b1, 1'b0, 1,  0};
        vecs[3]  = '{20'h80000, 0,  24'h000000, 24'hFF0000, 1'b1, 1'b0, 1,  0};
        vecs[4]  = '{20'h08000, 5,  24'h010010, 24'h010000, 1'b1, 1'b0, 7,  1};
        vecs[5]  = '{20'h08000, 5,  24'hFEFFF0, 24'hFF0000, 1'b1, 1'b0, 7,  1};
        vecs[6]  = '{20'h10000, 0,  24'h000000, 24'h000000, 1'b0, 1'b1, 66, 1};
        vecs[7]  = '{20'h64000, 0,  24'h000000, 24'h010000, 1'b1, 1'b0, 1,  0};
        vecs[8]  = '{20'h63FFF, 3,  24'h00C000, 24'h00C000, 1'b0, 1'b0, 5,  1};
        vecs[9]  = '{20'h9C000, 0,  24'h000000, 24'hFF0000, 1'b1, 1'b0, 1,  0};
        vecs[10] = '{20'h9C001, 64, 24'hFF0000, 24'hFF0000, 1'b0, 1'b0, 66, 1};
        vecs[11] = '{20'h08000, 1,  24'h010000, 24'h010000, 1'b0, 1'b0, 3,  1};

        for (int i = 0; i < 12; i++)
            run_txn(vecs[i].x, vecs[i].lat, vecs[i].tanh, 1, 1'b0,
                    vecs[i].ey, vecs[i].es, vecs[i].ee, vecs[i].ecyc, vecs[i].estarts);

        // Stray CDone in IDLE after a timeout must not produce output.
        run_txn(20'h04000, 0, 24'h0, 0, 1'b0, 24'h0, 1'b0, 1'b1, 66, 1);
        CDone = 1'b1; CTanh = 24'h00764D;
        tick();
        CDone = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stray_done_valid", {30'd0, OutValid, CStart}, 32'd0);
            tick();
        end

        // Stalled HOLD with a pending sample; it is accepted right after the handshake.
        run_txn(20'h70000, 0, 24'h0, 10, 1'b1, 24'h010000, 1'b1, 1'b0, 1, 0);
        chk("next_in_ready", {31'd0, InReady}, 32'd1);
        tick();
        InValid = 1'b0;
        chk("next_valid", {31'd0, OutValid}, 32'd1);
        chk("next_y", {8'd0, OutY}, 32'h00FF0000);
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;

        // Reset in the fifth WAIT cycle, then a late CDone that must be ignored.
        InX = 20'h08000; InValid = 1'b1;
        tick();
        InValid = 1'b0;
        chk("rw_start", {31'd0, CStart}, 32'd1);
        for (int i = 0; i < 5; i++) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("rw_in_ready", {31'd0, InReady}, 32'd1);
        chk("rw_cx", {12'd0, CX}, 32'd0);
        chk("rw_outs", {4'd0, CStart, OutValid, OutSat, OutErr, OutY}, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        CDone = 1'b1; CTanh = 24'h00764D;
        tick();
        CDone = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rw_late_done", {30'd0, OutValid, CStart}, 32'd0);
            tick();
        end

        // Randomized transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            rx = 20'($urandom);
            if (i % 2 == 1) rx = 20'($urandom_range(0, 20'h5FFFF)) ^ {$urandom_range(0, 1) == 1, 19'd0};
            rl = $urandom_range(0, 70);
            rt = 24'($urandom_range(0, 146000) - 73000);
            model(rx, rl, rt, my, ms, me, mc, mst);
            run_txn(rx, rl, rt, $urandom_range(0, 3), 1'b0, my, ms, me, mc, mst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
